// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: decode-side read ports, writeback-side write
// port and the ready flag. The master drives addresses/data, the slave
// (the register file) returns read data and ready.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
);
    logic                      rd_en;
    logic [NREAD*ADDR_W-1:0]   rs_addr;
    logic [NREAD*DATA_W-1:0]   rs_data;
    logic [ADDR_W-1:0]         waddr;
    logic [DATA_W-1:0]         wdata;
    logic                      wen;
    logic                      ready;

    modport master (
        output rd_en, rs_addr, waddr, wdata, wen,
        input  rs_data, ready
    );

    modport slave (
        input  rd_en, rs_addr, waddr, wdata, wen,
        output rs_data, ready
    );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised register file: one write port, NREAD registered read ports,
// optional hardwired zero entry, optional write-to-read bypass, and a read
// hold for pipeline stalls. The array has no reset, so a clear sweep zeroes
// every entry after reset before the file reports ready.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLEAR | sweeping zeros into entry r_clr_cnt, bus inputs ignored
// S_RUN   | normal read/write operation, left only through reset
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_mp_if.slave   bus
);
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]              r_state;
    logic [ADDR_W-1:0]       r_clr_cnt;
    logic [DATA_W-1:0]       r_mem [DEPTH];
    logic [NREAD*DATA_W-1:0] r_rs_data;

    logic                    w_run;
    logic                    w_mem_we;
    logic [ADDR_W-1:0]       w_mem_addr;
    logic [DATA_W-1:0]       w_mem_din;
    logic                    w_wr_zero;
    logic [ADDR_W-1:0]       w_rs_addr [NREAD];
    logic [DATA_W-1:0]       w_rd_next [NREAD];

    assign w_run     = (r_state == S_RUN);
    assign w_wr_zero = ZERO_REG && (bus.waddr == '0);

    // Clear sweep sequencer: one entry per cycle, then park in S_RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
                    if (r_clr_cnt == LAST_IDX) begin
                        r_state <= S_RUN;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    // Single array write port shared between the sweep and the writeback bus.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = bus.waddr;
        w_mem_din  = bus.wdata;
        if (!w_run) begin
            w_mem_we   = 1'b1;
            w_mem_addr = r_clr_cnt;
            w_mem_din  = '0;
        end else if (bus.wen && !w_wr_zero) begin
            w_mem_we   = 1'b1;
        end
    end

    // Storage array, deliberately without reset so it maps to plain flops/RAM.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_din;
        end
    end

    // Per-port next read value: zero entry, then bypass, then old contents.
    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            w_rs_addr[i] = bus.rs_addr[i*ADDR_W +: ADDR_W];
            w_rd_next[i] = r_mem[w_rs_addr[i]];
            if (ZERO_REG && (w_rs_addr[i] == '0)) begin
                w_rd_next[i] = '0;
            end else if (BYPASS && bus.wen && (bus.waddr == w_rs_addr[i])) begin
                w_rd_next[i] = bus.wdata;
            end
        end
    end

    // Registered read ports; rd_en low holds the last value across stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs_data <= '0;
        end else if (w_run && bus.rd_en) begin
            for (int i = 0; i < NREAD; i++) begin
                r_rs_data[i*DATA_W +: DATA_W] <= w_rd_next[i];
            end
        end
    end

    assign bus.rs_data = r_rs_data;
    assign bus.ready   = w_run;
endmodule
